// File: rtl/muxn1_rr_reg.sv
// N:1 registered mux with direct or round-robin selection behind a valid/ready output register.
// Optional parity output when MUX_PARITY_EN is defined.

module muxn1_rr_lane #(
  parameter int K     = 0,
  parameter int SEL_W = 2
) (
  input  logic             valid_i,
  input  logic [SEL_W-1:0] ptr_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic             upper_o,
  output logic             direct_o
);
  // upper_o: channel lies at or after the pointer, so it wins over any wrapped-around channel
  assign upper_o  = valid_i && (SEL_W'(K) >= ptr_i);
  assign direct_o = valid_i && (sel_i == SEL_W'(K));
endmodule

module muxn1_rr_reg #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]       valid_in,
  output logic [CHANNELS-1:0]       grant,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          selector,
  output logic [WIDTH-1:0]          data_out,
  output logic [SEL_W-1:0]          chan_out,
  output logic                      valid_out,
`ifdef MUX_PARITY_EN
  output logic                      parity_out,
`endif
  input  logic                      ready_out
);

  logic [WIDTH-1:0]    data_q;
  logic [SEL_W-1:0]    chan_q, rr_ptr_q, rr_ptr_d;
  logic                valid_q;
  logic [CHANNELS-1:0] upper, direct;
  logic [SEL_W-1:0]    pick;
  logic                found, load, take;
  logic [WIDTH-1:0]    sel_data;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    muxn1_rr_lane #(.K(k), .SEL_W(SEL_W)) u_lane (
      .valid_i  (valid_in[k]),
      .ptr_i    (rr_ptr_q),
      .sel_i    (selector),
      .upper_o  (upper[k]),
      .direct_o (direct[k])
    );
  end

  always_comb begin
    pick  = '0;
    found = 1'b0;
    if (mode) begin
      // lowest valid channel is the wrap-around fallback; lowest one at/after rr_ptr overrides it
      for (int k = CHANNELS-1; k >= 0; k--)
        if (valid_in[k]) begin
          pick  = SEL_W'(k);
          found = 1'b1;
        end
      for (int k = CHANNELS-1; k >= 0; k--)
        if (upper[k]) pick = SEL_W'(k);
    end else begin
      for (int k = 0; k < CHANNELS; k++)
        if (direct[k]) begin
          pick  = SEL_W'(k);
          found = 1'b1;
        end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (pick == SEL_W'(k)) sel_data = data_in[k*WIDTH +: WIDTH];
  end

  assign load = !valid_q || ready_out;
  assign take = reset_L && load && found;

  always_comb begin
    grant = '0;
    for (int k = 0; k < CHANNELS; k++)
      grant[k] = take && (pick == SEL_W'(k));
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (take && mode)
      rr_ptr_d = (pick == SEL_W'(CHANNELS-1)) ? '0 : pick + SEL_W'(1);
  end

`ifdef MUX_PARITY_EN
  logic parity_q;
  assign parity_out = parity_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      data_q   <= '0;
      chan_q   <= '0;
      valid_q  <= 1'b0;
      rr_ptr_q <= '0;
`ifdef MUX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (load) begin
        valid_q <= found;
        if (found) begin
          data_q <= sel_data;
          chan_q <= pick;
`ifdef MUX_PARITY_EN
          parity_q <= ^sel_data;
`endif
        end
      end
    end
  end

  assign data_out  = data_q;
  assign chan_out  = chan_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_muxn1_rr_reg.sv
// Bench for muxn1_rr_reg: directed table, randomized run against a scan-order model, 3-channel corner case.

module tb_muxn1_rr_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, mode4, rdy4, vout4;
  logic [7:0] din4;
  logic [3:0] vin4, g4;
  logic [1:0] sel4, dout4, chan4;

  logic       rst3, mode3, rdy3, vout3;
  logic [5:0] din3;
  logic [2:0] vin3, g3;
  logic [1:0] sel3, dout3, chan3;

`ifdef MUX_PARITY_EN
  logic par4, par3;
`endif

  muxn1_rr_reg #(.WIDTH(2), .CHANNELS(4), .SEL_W(2)) u_dut4 (
    .clk(clk), .reset_L(rst4), .data_in(din4), .valid_in(vin4), .grant(g4),
    .mode(mode4), .selector(sel4), .data_out(dout4), .chan_out(chan4),
    .valid_out(vout4),
`ifdef MUX_PARITY_EN
    .parity_out(par4),
`endif
    .ready_out(rdy4));

  muxn1_rr_reg #(.WIDTH(2), .CHANNELS(3), .SEL_W(2)) u_dut3 (
    .clk(clk), .reset_L(rst3), .data_in(din3), .valid_in(vin3), .grant(g3),
    .mode(mode3), .selector(sel3), .data_out(dout3), .chan_out(chan3),
    .valid_out(vout3),
`ifdef MUX_PARITY_EN
    .parity_out(par3),
`endif
    .ready_out(rdy3));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference state: the word held downstream and the round-robin start point
  logic       m_v;
  logic [1:0] m_d, m_c;
  int         m_ptr;

  function automatic int mpick(input logic [3:0] vin, input logic md, input logic [1:0] sel,
                               input logic rdy, input logic rst_n);
    int k;
    k = -1;
    if (md) begin
      for (int i = 0; i < 4; i++) begin
        int idx;
        idx = (m_ptr + i) % 4;
        if (k < 0 && vin[idx]) k = idx;
      end
    end else if (vin[sel]) k = int'(sel);
    if (!(rst_n && (!m_v || rdy))) k = -1;
    return k;
  endfunction

  task automatic mstep(input logic [3:0] vin, input logic [7:0] din, input logic md,
                       input logic [1:0] sel, input logic rdy, input logic rst_n);
    int k;
    logic ld;
    k  = mpick(vin, md, sel, rdy, rst_n);
    ld = !m_v || rdy;
    if (!rst_n) begin
      m_v = 0; m_d = 0; m_c = 0; m_ptr = 0;
    end else if (k >= 0) begin
      m_d = din[k*2 +: 2];
      m_c = 2'(k);
      m_v = 1;
      if (md) m_ptr = (k + 1) % 4;
    end else if (ld) m_v = 0;
  endtask

  task automatic cyc(input string nm, input logic rst_n, input logic [3:0] vin, input logic [7:0] din,
                     input logic md, input logic [1:0] sel, input logic rdy, input bit use_model,
                     input logic [3:0] eg, input logic ev, input logic [1:0] ed, input logic [1:0] ec);
    int k;
    @(negedge clk);
    rst4 = rst_n; vin4 = vin; din4 = din; mode4 = md; sel4 = sel; rdy4 = rdy;
    #1;
    k = mpick(vin, md, sel, rdy, rst_n);
    if (use_model) eg = (k >= 0) ? 4'(1 << k) : 4'h0;
    chk({nm, ".grant"}, 32'(g4), 32'(eg));
    @(posedge clk);
    mstep(vin, din, md, sel, rdy, rst_n);
    #1;
    if (use_model) begin
      ev = m_v; ed = m_d; ec = m_c;
    end
    chk({nm, ".valid_out"}, 32'(vout4), 32'(ev));
    chk({nm, ".data_out"}, 32'(dout4), 32'(ed));
    chk({nm, ".chan_out"}, 32'(chan4), 32'(ec));
`ifdef MUX_PARITY_EN
    chk({nm, ".parity_out"}, 32'(par4), 32'(^ed));
`endif
  endtask

  typedef struct {
    logic       rst_n;
    logic [3:0] vin;
    logic [7:0] din;
    logic       md;
    logic [1:0] sel;
    logic       rdy;
    logic [3:0] eg;
    logic       ev;
    logic [1:0] ed, ec;
  } vec_t;

  vec_t tbl[19];

  initial begin
    // reset
    tbl[0]  = '{0, 4'hF, 8'hE4, 1, 0, 1, 4'h0, 0, 0, 0};
    tbl[1]  = '{0, 4'hF, 8'hE4, 1, 0, 1, 4'h0, 0, 0, 0};
    // direct select of ch2
    tbl[2]  = '{1, 4'h4, 8'h30, 0, 2, 1, 4'h4, 1, 3, 2};
    // round-robin over all valid
    tbl[3]  = '{1, 4'hF, 8'hE4, 1, 0, 1, 4'h1, 1, 0, 0};
    tbl[4]  = '{1, 4'hF, 8'hE4, 1, 0, 1, 4'h2, 1, 1, 1};
    tbl[5]  = '{1, 4'hF, 8'hE4, 1, 0, 1, 4'h4, 1, 2, 2};
    tbl[6]  = '{1, 4'hF, 8'hE4, 1, 0, 1, 4'h8, 1, 3, 3};
    tbl[7]  = '{1, 4'hF, 8'hE4, 1, 0, 1, 4'h1, 1, 0, 0};
    // skip from ptr=1 to ch3, then wrap to ch0
    tbl[8]  = '{1, 4'h9, 8'hE4, 1, 0, 1, 4'h8, 1, 3, 3};
    tbl[9]  = '{1, 4'h9, 8'hE4, 1, 0, 1, 4'h1, 1, 0, 0};
    // backpressure, then release
    tbl[10] = '{1, 4'hF, 8'hE4, 1, 0, 0, 4'h0, 1, 0, 0};
    tbl[11] = '{1, 4'hF, 8'hE4, 1, 0, 0, 4'h0, 1, 0, 0};
    tbl[12] = '{1, 4'hF, 8'hE4, 1, 0, 0, 4'h0, 1, 0, 0};
    tbl[13] = '{1, 4'hF, 8'hE4, 1, 0, 1, 4'h2, 1, 1, 1};
    // nothing valid: valid drops, data/chan hold
    tbl[14] = '{1, 4'h0, 8'hE4, 1, 0, 1, 4'h0, 0, 1, 1};
    // direct select of an invalid channel, then a valid one
    tbl[15] = '{1, 4'hB, 8'hE4, 0, 2, 1, 4'h0, 0, 1, 1};
    tbl[16] = '{1, 4'hF, 8'hE4, 0, 1, 1, 4'h2, 1, 1, 1};
    // rr_ptr untouched by mode 0 captures: still 2
    tbl[17] = '{1, 4'hF, 8'hE4, 1, 0, 1, 4'h4, 1, 2, 2};
    // mid-operation reset
    tbl[18] = '{0, 4'hF, 8'hE4, 1, 0, 1, 4'h0, 0, 0, 0};
  end

  initial begin
    rst4 = 0; vin4 = 0; din4 = 0; mode4 = 0; sel4 = 0; rdy4 = 1;
    rst3 = 0; vin3 = 0; din3 = 0; mode3 = 0; sel3 = 0; rdy3 = 1;
    m_v = 0; m_d = 0; m_c = 0; m_ptr = 0;

    for (int i = 0; i < 19; i++)
      cyc($sformatf("vec%0d", i), tbl[i].rst_n, tbl[i].vin, tbl[i].din, tbl[i].md,
          tbl[i].sel, tbl[i].rdy, 0, tbl[i].eg, tbl[i].ev, tbl[i].ed, tbl[i].ec);

    for (int i = 0; i < 400; i++)
      cyc($sformatf("rnd%0d", i), ($urandom_range(0, 39) != 0), 4'($urandom), 8'($urandom),
          1'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0), 1, 0, 0, 0, 0);

    // 3-channel instance: out-of-range selector never grants
    @(negedge clk); rst3 = 0; vin3 = 3'b111;
    @(negedge clk); rst3 = 1; mode3 = 0; sel3 = 0; rdy3 = 0; din3 = 6'b10_01_11;
    #1 chk("c3.grant_sel0", 32'(g3), 32'h1);
    @(posedge clk); #1;
    chk("c3.valid_first", 32'(vout3), 32'h1);
    chk("c3.data_first", 32'(dout3), 32'h3);
    chk("c3.chan_first", 32'(chan3), 32'h0);
    @(negedge clk); sel3 = 2'd3;
    #1 chk("c3.grant_stall", 32'(g3), 32'h0);
    @(posedge clk); #1;
    chk("c3.valid_stall", 32'(vout3), 32'h1);
    chk("c3.data_stall", 32'(dout3), 32'h3);
    @(negedge clk); rdy3 = 1;
    #1 chk("c3.grant_sel3", 32'(g3), 32'h0);
    @(posedge clk); #1;
    chk("c3.valid_drop", 32'(vout3), 32'h0);
    chk("c3.chan_hold", 32'(chan3), 32'h0);
    chk("c3.data_hold", 32'(dout3), 32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
